// File: rtl/fifo_pkg.sv
// Shared async FIFO parameters and word type.
// Used by the FIFO core and its read-side streaming adapter.
package fifo_pkg;

  localparam int FIFO_WIDTH      = 8;
  localparam int FIFO_DEPTH      = 16;
  localparam int FIFO_ADDR       = 4;
  localparam int RD_STREAM_DEPTH = 4;

  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/rd_stream_buf.sv
// Circular prefetch storage for fifo_rd_stream.
// Write at tail on capture, indexed read at head.
module rd_stream_buf #(
  parameter int SW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [SW-1:0] wr_data,
  input  logic [AW-1:0] rd_idx,
  output logic [SW-1:0] rd_data
);

  logic [SW-1:0] mem [DEPTH];

  // Cleared so the head word reads as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fifo_rd_stream.sv
// Async FIFO read side re-presented as a valid/ready stream.
// Define FIFO_RD_STREAM_PARITY_EN to store parity and add m_parity_err.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = RD_STREAM_DEPTH,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
`ifdef FIFO_RD_STREAM_PARITY_EN
  output logic             m_parity_err,
`endif
  output logic [AW:0]      m_count
);

`ifdef FIFO_RD_STREAM_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif

  logic [AW:0]   occ;
  logic          inflight;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW+1:0] credit;
  logic          pop;
  logic [SW-1:0] wr_word;
  logic [SW-1:0] rd_q;

  // Words already requested count against space, so no overrun.
  assign credit = {1'b0, occ} + (AW+2)'(inflight);
  assign fifo_rd_en = ~fifo_empty
                    & (credit < (AW+2)'(DEPTH));

  assign m_valid = (occ != '0);
  assign pop     = m_valid & m_ready;
  assign m_count = occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= '0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= fifo_rd_en;
      occ      <= occ + (AW+1)'(inflight)
                      - (AW+1)'(pop);
      if (inflight) tail <= tail + AW'(1);
      if (pop)      head <= head + AW'(1);
    end
  end

`ifdef FIFO_RD_STREAM_PARITY_EN
  assign wr_word = {^fifo_data, fifo_data};
  assign m_parity_err = m_valid
                      & (rd_q[WIDTH] != ^rd_q[WIDTH-1:0]);
`else
  assign wr_word = fifo_data;
`endif

  assign m_data = rd_q[WIDTH-1:0];

  rd_stream_buf #(
    .SW    (SW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight),
    .wr_idx  (tail),
    .wr_data (wr_word),
    .rd_idx  (head),
    .rd_data (rd_q)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed plus random bench for fifo_rd_stream.
// A queue models the FIFO; a second queue is the expected stream.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_data = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [W-1:0]  m_data;
  logic [AW:0]   m_count;
`ifdef FIFO_RD_STREAM_PARITY_EN
  logic          m_parity_err;
  logic [W:0]    pq;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;

  fifo_word_t fq[$];
  fifo_word_t exp_q[$];

  fifo_rd_stream #(.WIDTH(W), .DEPTH(D), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
`ifdef FIFO_RD_STREAM_PARITY_EN
    .m_parity_err (m_parity_err),
`endif
    .m_count      (m_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // FIFO model: data registered one cycle after the strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      fifo_data  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en && fq.size() != 0)
        fifo_data <= fq.pop_front();
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Stream monitor: order, hold-under-backpressure, occupancy bound.
  logic         pv_hold = 1'b0;
  logic [W-1:0] pv_data = '0;
  fifo_word_t   exp_w;
  always @(negedge clk) begin
    if (rst) begin
      pv_hold = 1'b0;
    end else begin
      if (pv_hold) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pv_data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", m_valid, 0);
        end else begin
          exp_w = exp_q.pop_front();
          chk("word_order", m_data, exp_w);
          hs_cnt++;
        end
      end
      chk("count_bound", m_count <= (AW+1)'(D), 1);
      chk("valid_vs_count", m_valid, m_count != 0);
      pv_hold = m_valid & ~m_ready;
      pv_data = m_data;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input fifo_word_t w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic drain(input string tag,
                       input int lim, input bit tog);
    int k = 0;
    while ((exp_q.size() != 0 || m_valid) && k < lim) begin
      tick();
      if (tog) m_ready = ~m_ready;
      k++;
    end
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_count"}, m_count, 0);
  endtask

  initial begin
    int fr, fv, lv, nv, rds, k;

    repeat (3) tick();
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_count", m_count, 0);
    chk("rst_data", m_data, 0);
    rst = 1'b0;

    // Idle with FIFO empty
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_rd_en", fifo_rd_en, 0);
      chk("idle_valid", m_valid, 0);
      chk("idle_count", m_count, 0);
      chk("idle_data", m_data, 0);
    end

    // Full-rate streaming
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) push(fifo_word_t'(i));
    fr = -1; fv = -1; lv = -1; nv = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fifo_rd_en && fr < 0) fr = i;
      if (m_valid && fv < 0) fv = i;
      if (m_valid) begin nv++; lv = i; end
    end
    chk("lat_strobe_to_valid", fv - fr, 2);
    chk("stream_words", nv, 16);
    chk("stream_consec", lv - fv, 15);
    chk("stream_count", m_count, 0);
    chk("stream_left", exp_q.size(), 0);

    // Back-pressure
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(fifo_word_t'(i));
    rds = 0;
    repeat (12) begin
      tick();
      if (fifo_rd_en) rds++;
    end
    chk("bp_reads", rds, 4);
    chk("bp_count", m_count, 4);
    chk("bp_rd_en", fifo_rd_en, 0);
    chk("bp_data", m_data, 8'h01);
`ifdef FIFO_RD_STREAM_PARITY_EN
    chk("parity_ok", m_parity_err, 0);
    pq = dut.rd_q;
    force dut.rd_q = {~pq[W], pq[W-1:0]};
    #1;
    chk("parity_err", m_parity_err, 1);
    release dut.rd_q;
    #1;
`endif
    m_ready = 1'b1;
    drain("bp", 60, 1'b0);

    // Random words, ready toggling every cycle
    for (int i = 0; i < 20; i++)
      push(fifo_word_t'($urandom_range(255)));
    drain("wrap", 200, 1'b1);
    m_ready = 1'b1;

    // FIFO goes empty right behind a strobe
    push(8'h5A);
    rds = 0;
    repeat (8) begin
      tick();
      if (fifo_rd_en) rds++;
    end
    chk("edge_reads", rds, 1);
    chk("edge_left", exp_q.size(), 0);
    chk("edge_count", m_count, 0);

    // Asynchronous reset mid-stream
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(fifo_word_t'($urandom_range(255)));
    k = 0;
    while (m_count != 3 && k < 20) begin
      tick();
      k++;
    end
    chk("mid_count3", m_count, 3);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_count", m_count, 0);
    chk("mid_rst_data", m_data, 0);
    tick();
    tick();
    rst = 1'b0;
    push(8'hC3);
    push(8'h3C);
    m_ready = 1'b1;
    drain("post_rst", 40, 1'b0);
    chk("post_rst_hs", hs_cnt, 16 + 8 + 20 + 1 + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
